bike_sampler_uniform_multi: RTL and testbench
=============================================

Name: bike_sampler_uniform_multi

Overview:
Parametrised uniform-string sampler, successor to the single-string 32-bit sampler. Fills NUM_CHANNELS independent BRAM buffers, each holding a uniform string of SAMPLE_LENGTH bits, from a RAND_VALID/RAND_REQU randomness stream of configurable word width. Masks unused bits of each final word and supports abort. Used in BIKE keygen/encaps, where several uniform strings (e.g. h0/h1 seeds, m) must be drawn back-to-back in one run.

Parameters:
SAMPLE_LENGTH, 256, bits per uniform string (≥1)
WORD_WIDTH, 32, width of NEW_RAND and DOUT, i.e. the BRAM word width (≥8)
NUM_CHANNELS, 2, number of strings/buffers filled per run (≥1)
Derived: WORDS = ceil(SAMPLE_LENGTH/WORD_WIDTH); AW = max(1, clog2(WORDS)); SW = max(1, clog2(NUM_CHANNELS)); REM = SAMPLE_LENGTH mod WORD_WIDTH

Ports:
CLK  in  1  system clock
RESETN  in  1  asynchronous active-low reset
ENABLE  in  1  level start; deassertion aborts or ends a run
DONE  out  1  high while all channels are written and ENABLE is still high
RAND_VALID  in  1  NEW_RAND holds a valid word
RAND_REQU  out  1  sampler accepts a word this cycle
NEW_RAND  in  WORD_WIDTH  randomness word
WREN  out  1  BRAM write strobe
SEL  out  SW  target channel/buffer index
ADDR  out  AW  word address within the selected buffer
DOUT  out  WORD_WIDTH  write data

Behaviour:
- Reset (RESETN=0, async): state S_IDLE; word and channel counters 0; DONE=0. Combinational outputs then resolve to RAND_REQU=0, WREN=0, DOUT=0, SEL=0, ADDR=0.
- States: S_IDLE, S_SAMPLE, S_DONE.
- S_IDLE: when ENABLE=1, go to S_SAMPLE next cycle. Counters stay 0.
- S_SAMPLE: RAND_REQU=1 (combinational from state). Handshake fires when RAND_VALID=1 in the same cycle.
- WREN = RAND_VALID & RAND_REQU, same cycle, zero latency. ADDR = word counter. SEL = channel counter.
- DOUT = NEW_RAND on a handshake, else all-zero.
- Last word of each string (word counter = WORDS-1): if REM≠0, bits [WORD_WIDTH-1:REM] are forced to 0. If REM=0, no masking.
- Counter advance, on each handshake only:
  - word counter increments.
  - At WORDS-1 it wraps to 0 and the channel counter increments.
  - Handshake at word WORDS-1 of channel NUM_CHANNELS-1 is the final write: go to S_DONE and clear both counters.
- RAND_VALID=0 stalls: no write, counters hold, no timeout.
- S_DONE: DONE=1 (registered; first high the cycle after the final write). RAND_REQU=0; NEW_RAND is ignored. Hold until ENABLE=0, then go to S_IDLE with DONE=0 next cycle.
- Abort: ENABLE=0 in S_SAMPLE goes to S_IDLE next cycle, counters cleared, DONE never asserted. A handshake in the abort cycle is still written. Partial buffer contents are undefined to consumers.
- ENABLE held high after returning to S_IDLE (abort) starts a fresh run from channel 0, word 0.
- Total handshakes per run: NUM_CHANNELS*WORDS. Minimum run length with RAND_VALID tied high: 1 + NUM_CHANNELS*WORDS cycles from ENABLE to DONE.
- Async reset mid-run behaves as abort. Counters never exceed WORDS-1 / NUM_CHANNELS-1.

Decomposition:
- Package bike_sampler_pkg:
  - state enum (S_IDLE, S_SAMPLE, S_DONE)
  - function ceil_div(a, b)
  - function last_mask(len, width) returning the WORD_WIDTH-bit keep-mask (all-ones when REM=0)
- Sub-module bike_sampler_word_ctr: two-level wrap counter (word/channel).
  - Inputs: inc, clr.
  - Outputs: word, chan, last_word, last_all.
  - Async active-low reset.
  - Parametrised by WORDS and NUM_CHANNELS.

Test Plan:
- SAMPLE_LENGTH=80, WORD_WIDTH=32, NUM_CHANNELS=2, RAND_VALID=1, NEW_RAND=0xFFFFFFFF → 6 writes (SEL,ADDR) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2). Writes at ADDR=2 carry DOUT=0x0000FFFF, all others 0xFFFFFFFF. DONE rises 1 cycle after the 6th write; ENABLE to DONE = 7 cycles.
- SAMPLE_LENGTH=256, WORD_WIDTH=64, NUM_CHANNELS=1, RAND_VALID toggling 1,0,1,0 → exactly 4 writes with ADDR 0..3, unmasked. Stall cycles show WREN=0, DOUT=0, counters held.
- Abort: ENABLE dropped after 2 handshakes → state S_IDLE next cycle, DONE stays 0. Re-asserting ENABLE restarts with first write at SEL=0, ADDR=0.
- RESETN pulsed low asynchronously mid-run (between clock edges) → outputs immediately RAND_REQU=0, WREN=0, DONE=0. After release plus ENABLE=1, a full run completes.
- S_DONE with ENABLE held high for 10 cycles and RAND_VALID=1 → no WREN, DONE stays 1. ENABLE=0 gives DONE=0 one cycle later.
- SAMPLE_LENGTH=5, WORD_WIDTH=8, NUM_CHANNELS=3 (AW=1 edge, WORDS=1), NEW_RAND=0xFF → 3 writes with ADDR=0, SEL=0,1,2, DOUT=0x1F each.

Source files
------------

// File: rtl/bike_sampler_pkg.sv
// bike_sampler_pkg: shared state encoding and constant helpers for the uniform sampler.
package bike_sampler_pkg;

  localparam int MAX_W = 1024;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Keep-mask for the final word of a string; all-ones when the length is a word multiple.
  function automatic logic [MAX_W-1:0] last_mask(input int len, input int width);
    int rem;
    logic [MAX_W-1:0] ones;
    rem  = len % width;
    ones = '1;
    return ones >> (MAX_W - ((rem == 0) ? width : rem));
  endfunction

endpackage

// File: rtl/bike_sampler_word_ctr.sv
// bike_sampler_word_ctr: word counter nested inside a channel counter, wrapping at WORDS / NUM_CHANNELS.
module bike_sampler_word_ctr #(
  parameter int WORDS        = 8,
  parameter int NUM_CHANNELS = 2,
  parameter int AW           = 3,
  parameter int SW           = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [AW-1:0] word,
  output logic [SW-1:0] chan,
  output logic          last_word,
  output logic          last_all
);

  logic [AW-1:0] word_q, word_d;
  logic [SW-1:0] chan_q, chan_d;

  always_comb begin
    last_word = word_q == AW'(WORDS - 1);
    last_all  = last_word && (chan_q == SW'(NUM_CHANNELS - 1));
    word_d    = (clr || (inc && last_word)) ? '0 : inc ? word_q + AW'(1) : word_q;
    chan_d    = (clr || (inc && last_all)) ? '0 : (inc && last_word) ? chan_q + SW'(1) : chan_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      chan_q <= '0;
    end else begin
      word_q <= word_d;
      chan_q <= chan_d;
    end
  end

  assign word = word_q;
  assign chan = chan_q;

endmodule

// File: rtl/bike_sampler_uniform_multi.sv
// bike_sampler_uniform_multi: streams randomness words into NUM_CHANNELS BRAM buffers,
// masking the tail of each string's last word; ENABLE low aborts or ends a run.
module bike_sampler_uniform_multi
  import bike_sampler_pkg::*;
#(
  parameter int SAMPLE_LENGTH = 256,
  parameter int WORD_WIDTH    = 32,
  parameter int NUM_CHANNELS  = 2,
  localparam int WORDS = ceil_div(SAMPLE_LENGTH, WORD_WIDTH),
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int SW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  ENABLE,
  output logic                  DONE,
  input  logic                  RAND_VALID,
  output logic                  RAND_REQU,
  input  logic [WORD_WIDTH-1:0] NEW_RAND,
  output logic                  WREN,
  output logic [SW-1:0]         SEL,
  output logic [AW-1:0]         ADDR,
  output logic [WORD_WIDTH-1:0] DOUT
);

  localparam logic [WORD_WIDTH-1:0] KEEP = WORD_WIDTH'(last_mask(SAMPLE_LENGTH, WORD_WIDTH));

  state_t state_q, state_d;
  logic   done_q, done_d;
  logic   last_word, last_all, ctr_clr;

  // Counters clear whenever no run is in progress, including the abort cycle itself.
  assign ctr_clr = !ENABLE || (state_q != S_SAMPLE);

  bike_sampler_word_ctr #(
    .WORDS       (WORDS),
    .NUM_CHANNELS(NUM_CHANNELS),
    .AW          (AW),
    .SW          (SW)
  ) u_ctr (
    .clk      (CLK),
    .rst_n    (RESETN),
    .inc      (WREN),
    .clr      (ctr_clr),
    .word     (ADDR),
    .chan     (SEL),
    .last_word(last_word),
    .last_all (last_all)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = ENABLE ? S_SAMPLE : S_IDLE;
      S_SAMPLE: state_d = !ENABLE ? S_IDLE : (WREN && last_all) ? S_DONE : S_SAMPLE;
      S_DONE:   state_d = ENABLE ? S_DONE : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    done_d = state_d == S_DONE;
  end

  always_comb begin
    RAND_REQU = state_q == S_SAMPLE;
    WREN      = RAND_VALID && RAND_REQU;
    DOUT      = WREN ? (NEW_RAND & (last_word ? KEEP : '1)) : '0;
    DONE      = done_q;
  end

endmodule

// File: tb/tb_bike_sampler_uniform_multi.sv
// tb_bike_sampler_uniform_multi: three sampler configurations driven by directed runs,
// with expected writes queued per instance and checked by negedge monitors.
module tb_bike_sampler_uniform_multi;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    int          addr;
    logic [63:0] dout;
  } exp_t;

  exp_t qa[$], qb[$], qc[$];
  int checks = 0;
  int failures = 0;

  logic        en_a = 1'b0, rv_a = 1'b1, done_a, rq_a, wr_a;
  logic [31:0] nr_a = 32'hFFFF_FFFF, dout_a;
  logic [0:0]  sel_a;
  logic [1:0]  addr_a;

  logic        en_b = 1'b0, rv_b = 1'b0, done_b, rq_b, wr_b;
  logic [63:0] nr_b = '0, dout_b;
  logic [0:0]  sel_b;
  logic [1:0]  addr_b;

  logic        en_c = 1'b0, rv_c = 1'b1, done_c, rq_c, wr_c;
  logic [7:0]  nr_c = 8'hFF, dout_c;
  logic [1:0]  sel_c;
  logic [0:0]  addr_c;

  bike_sampler_uniform_multi #(.SAMPLE_LENGTH(80), .WORD_WIDTH(32), .NUM_CHANNELS(2)) dut_a (
    .CLK(clk), .RESETN(rst_n), .ENABLE(en_a), .DONE(done_a), .RAND_VALID(rv_a), .RAND_REQU(rq_a),
    .NEW_RAND(nr_a), .WREN(wr_a), .SEL(sel_a), .ADDR(addr_a), .DOUT(dout_a));

  bike_sampler_uniform_multi #(.SAMPLE_LENGTH(256), .WORD_WIDTH(64), .NUM_CHANNELS(1)) dut_b (
    .CLK(clk), .RESETN(rst_n), .ENABLE(en_b), .DONE(done_b), .RAND_VALID(rv_b), .RAND_REQU(rq_b),
    .NEW_RAND(nr_b), .WREN(wr_b), .SEL(sel_b), .ADDR(addr_b), .DOUT(dout_b));

  bike_sampler_uniform_multi #(.SAMPLE_LENGTH(5), .WORD_WIDTH(8), .NUM_CHANNELS(3)) dut_c (
    .CLK(clk), .RESETN(rst_n), .ENABLE(en_c), .DONE(done_c), .RAND_VALID(rv_c), .RAND_REQU(rq_c),
    .NEW_RAND(nr_c), .WREN(wr_c), .SEL(sel_c), .ADDR(addr_c), .DOUT(dout_c));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (wr_a === 1'b1) begin
      chk("a_write_expected", 64'(qa.size() > 0), 64'd1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_sel", 64'(sel_a), 64'(e.sel));
        chk("a_addr", 64'(addr_a), 64'(e.addr));
        chk("a_dout", 64'(dout_a), e.dout);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (wr_b === 1'b1) begin
      chk("b_write_expected", 64'(qb.size() > 0), 64'd1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_sel", 64'(sel_b), 64'(e.sel));
        chk("b_addr", 64'(addr_b), 64'(e.addr));
        chk("b_dout", dout_b, e.dout);
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (wr_c === 1'b1) begin
      chk("c_write_expected", 64'(qc.size() > 0), 64'd1);
      if (qc.size() > 0) begin
        e = qc.pop_front();
        chk("c_sel", 64'(sel_c), 64'(e.sel));
        chk("c_addr", 64'(addr_c), 64'(e.addr));
        chk("c_dout", 64'(dout_c), e.dout);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push_a(input int n);
    for (int k = 0; k < n; k++)
      qa.push_back('{k / 3, k % 3, (k % 3 == 2) ? 64'h0000_FFFF : 64'hFFFF_FFFF});
  endfunction

  function automatic logic [63:0] dat_b(input int k);
    return 64'h1111_1111_1111_1111 * 64'(k + 1);
  endfunction

  task automatic wait_done_a(output int n);
    n = 0;
    while (done_a !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("a_done_reached", 64'(done_a), 64'd1);
  endtask

  initial begin
    int n;
    #3;
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_requ", 64'(rq_a), 64'd0);
    chk("rst_wren", 64'(wr_a), 64'd0);
    chk("rst_dout", 64'(dout_a), 64'd0);
    chk("rst_sel", 64'(sel_a), 64'd0);
    chk("rst_addr", 64'(addr_a), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    push_a(6);
    en_a = 1'b1;
    wait_done_a(n);
    chk("a_en_to_done", 64'(n), 64'd7);
    chk("a_q_drained", 64'(qa.size()), 64'd0);
    repeat (10) begin
      tick();
      chk("a_hold_done", 64'(done_a), 64'd1);
      chk("a_hold_wren", 64'(wr_a), 64'd0);
      chk("a_hold_requ", 64'(rq_a), 64'd0);
    end
    en_a = 1'b0;
    tick();
    chk("a_done_clear", 64'(done_a), 64'd0);

    push_a(2);
    en_a = 1'b1;
    tick();
    tick();
    en_a = 1'b0;
    tick();
    chk("abort_requ", 64'(rq_a), 64'd0);
    chk("abort_q_drained", 64'(qa.size()), 64'd0);
    repeat (3) begin
      tick();
      chk("abort_done_low", 64'(done_a), 64'd0);
    end
    push_a(6);
    en_a = 1'b1;
    wait_done_a(n);
    chk("restart_en_to_done", 64'(n), 64'd7);
    en_a = 1'b0;
    tick();

    push_a(2);
    en_a = 1'b1;
    tick();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_requ", 64'(rq_a), 64'd0);
    chk("arst_wren", 64'(wr_a), 64'd0);
    chk("arst_done", 64'(done_a), 64'd0);
    chk("arst_addr", 64'(addr_a), 64'd0);
    tick();
    rst_n = 1'b1;
    chk("arst_q_drained", 64'(qa.size()), 64'd0);
    push_a(6);
    wait_done_a(n);
    chk("arst_rerun_to_done", 64'(n), 64'd7);
    en_a = 1'b0;
    tick();

    for (int k = 0; k < 4; k++) qb.push_back('{0, k, dat_b(k)});
    en_b = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      rv_b = (i % 2 == 0);
      nr_b = rv_b ? dat_b(i / 2) : 64'hDEAD_BEEF_DEAD_BEEF;
      #3;
      if (!rv_b) begin
        chk("b_stall_wren", 64'(wr_b), 64'd0);
        chk("b_stall_dout", dout_b, 64'd0);
        chk("b_stall_addr", 64'(addr_b), 64'(i / 2 + 1));
      end
      tick();
    end
    rv_b = 1'b0;
    chk("b_done", 64'(done_b), 64'd1);
    chk("b_q_drained", 64'(qb.size()), 64'd0);
    en_b = 1'b0;
    tick();
    chk("b_done_clear", 64'(done_b), 64'd0);

    for (int s = 0; s < 3; s++) qc.push_back('{s, 0, 64'h1F});
    en_c = 1'b1;
    n = 0;
    while (done_c !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("c_en_to_done", 64'(n), 64'd4);
    chk("c_q_drained", 64'(qc.size()), 64'd0);
    en_c = 1'b0;
    tick();
    chk("c_done_clear", 64'(done_c), 64'd0);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
